// File: rtl/fetch_run_controller.sv
// rtl/fetch_run_controller.sv - byte-stream program loader and PC run/step sequencer for the fetch stage
// Loads program words from the debug UART, then drives PC clear/enable in continuous or single-step mode until HALT.
module fetch_run_controller #(
    parameter int NB_INSTRUC        = 32,
    parameter int NB_BYTE           = 8,
    parameter int RAM_DEPTH_PROGRAM = 2048,
    parameter int NB_MEM_ADDR       = 11
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic [NB_BYTE-1:0]     i_rx_data,
    input  logic                   i_rx_valid,
    input  logic                   i_halt,
    output logic                   o_mem_wr_en,
    output logic [NB_MEM_ADDR-1:0] o_mem_wr_addr,
    output logic [NB_INSTRUC-1:0]  o_mem_wr_data,
    output logic                   o_pc_clear,
    output logic                   o_pc_enable,
    output logic [NB_MEM_ADDR:0]   o_loaded_count,
    output logic [2:0]             o_state,
    output logic                   o_done,
    output logic                   o_error
);

    localparam int NB_CNT         = NB_MEM_ADDR + 1;
    localparam int NB_LEN         = 2 * NB_BYTE;
    localparam int BYTES_PER_WORD = NB_INSTRUC / NB_BYTE;
    localparam int NB_BIDX        = $clog2(BYTES_PER_WORD);
    localparam int NB_SHIFT       = NB_INSTRUC - NB_BYTE;

    localparam logic [NB_BIDX-1:0] LAST_BYTE = NB_BIDX'(BYTES_PER_WORD - 1);
    localparam logic [NB_LEN-1:0]  MAX_WORDS = NB_LEN'(RAM_DEPTH_PROGRAM);

    localparam logic [NB_BYTE-1:0] CMD_LOAD  = NB_BYTE'(8'h4C);
    localparam logic [NB_BYTE-1:0] CMD_CONT  = NB_BYTE'(8'h43);
    localparam logic [NB_BYTE-1:0] CMD_STEP  = NB_BYTE'(8'h53);
    localparam logic [NB_BYTE-1:0] CMD_NEXT  = NB_BYTE'(8'h4E);
    localparam logic [NB_BYTE-1:0] CMD_HALT  = NB_BYTE'(8'h48);
    localparam logic [NB_BYTE-1:0] CMD_RESET = NB_BYTE'(8'h52);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CNT_HI = 3'd1,
        ST_CNT_LO = 3'd2,
        ST_LOAD   = 3'd3,
        ST_RUN    = 3'd4,
        ST_STEP   = 3'd5,
        ST_DONE   = 3'd6
    } state_t;

    state_t                r_state;
    logic [NB_BYTE-1:0]    r_cnt_hi;
    logic [NB_CNT-1:0]     r_word_total;
    logic [NB_CNT-1:0]     r_word_idx;
    logic [NB_BIDX-1:0]    r_byte_idx;
    logic [NB_SHIFT-1:0]   r_shift;
    logic                  r_wr_en;
    logic [NB_MEM_ADDR-1:0] r_wr_addr;
    logic [NB_INSTRUC-1:0] r_wr_data;
    logic                  r_pc_clear;
    logic                  r_pc_enable;
    logic [NB_CNT-1:0]     r_loaded_count;
    logic                  r_error;

    state_t                w_state_nxt;
    logic [NB_BYTE-1:0]    w_cnt_hi_nxt;
    logic [NB_CNT-1:0]     w_word_total_nxt;
    logic [NB_CNT-1:0]     w_word_idx_nxt;
    logic [NB_BIDX-1:0]    w_byte_idx_nxt;
    logic [NB_SHIFT-1:0]   w_shift_nxt;
    logic                  w_wr_en_nxt;
    logic [NB_MEM_ADDR-1:0] w_wr_addr_nxt;
    logic [NB_INSTRUC-1:0] w_wr_data_nxt;
    logic                  w_pc_clear_nxt;
    logic                  w_pc_enable_nxt;
    logic [NB_CNT-1:0]     w_loaded_count_nxt;
    logic                  w_error_nxt;

    logic [NB_LEN-1:0]     w_count;
    logic [NB_CNT-1:0]     w_word_idx_inc;
    logic                  w_stop;

    assign w_count        = {r_cnt_hi, i_rx_data};
    assign w_word_idx_inc = r_word_idx + NB_CNT'(1);
    // A pipeline HALT and a host 'H' byte end RUN/STEP identically
    assign w_stop         = i_halt || (i_rx_valid && (i_rx_data == CMD_HALT));

    always_comb begin
        w_state_nxt        = r_state;
        w_cnt_hi_nxt       = r_cnt_hi;
        w_word_total_nxt   = r_word_total;
        w_word_idx_nxt     = r_word_idx;
        w_byte_idx_nxt     = r_byte_idx;
        w_shift_nxt        = r_shift;
        w_wr_en_nxt        = 1'b0;
        w_wr_addr_nxt      = r_wr_addr;
        w_wr_data_nxt      = r_wr_data;
        w_pc_clear_nxt     = 1'b0;
        w_pc_enable_nxt    = 1'b0;
        w_loaded_count_nxt = r_loaded_count;
        w_error_nxt        = r_error;

        case (r_state)
            ST_IDLE: begin
                if (i_rx_valid) begin
                    if (i_rx_data == CMD_LOAD) begin
                        // Memory is about to be overwritten, so the old count no longer describes it
                        w_state_nxt        = ST_CNT_HI;
                        w_error_nxt        = 1'b0;
                        w_loaded_count_nxt = '0;
                        w_word_idx_nxt     = '0;
                        w_byte_idx_nxt     = '0;
                    end else if ((i_rx_data == CMD_CONT) && (r_loaded_count != '0)) begin
                        w_state_nxt    = ST_RUN;
                        w_pc_clear_nxt = 1'b1;
                    end else if ((i_rx_data == CMD_STEP) && (r_loaded_count != '0)) begin
                        w_state_nxt    = ST_STEP;
                        w_pc_clear_nxt = 1'b1;
                    end
                end
            end
            ST_CNT_HI: begin
                if (i_rx_valid) begin
                    w_cnt_hi_nxt = i_rx_data;
                    w_state_nxt  = ST_CNT_LO;
                end
            end
            ST_CNT_LO: begin
                if (i_rx_valid) begin
                    if (w_count == '0) begin
                        w_state_nxt = ST_IDLE;
                    end else if (w_count > MAX_WORDS) begin
                        w_state_nxt = ST_IDLE;
                        w_error_nxt = 1'b1;
                    end else begin
                        w_word_total_nxt = w_count[NB_CNT-1:0];
                        w_state_nxt      = ST_LOAD;
                    end
                end
            end
            ST_LOAD: begin
                if (i_rx_valid) begin
                    if (r_byte_idx == LAST_BYTE) begin
                        w_wr_en_nxt    = 1'b1;
                        w_wr_addr_nxt  = r_word_idx[NB_MEM_ADDR-1:0];
                        w_wr_data_nxt  = {r_shift, i_rx_data};
                        w_byte_idx_nxt = '0;
                        w_word_idx_nxt = w_word_idx_inc;
                        if (w_word_idx_inc == r_word_total) begin
                            w_loaded_count_nxt = r_word_total;
                            w_state_nxt        = ST_IDLE;
                        end
                    end else begin
                        w_shift_nxt    = {r_shift[NB_SHIFT-NB_BYTE-1:0], i_rx_data};
                        w_byte_idx_nxt = r_byte_idx + NB_BIDX'(1);
                    end
                end
            end
            ST_RUN: begin
                if (w_stop) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    w_pc_enable_nxt = 1'b1;
                end
            end
            ST_STEP: begin
                // Halt has priority over a coincident 'N': no enable pulse is issued
                if (w_stop) begin
                    w_state_nxt = ST_DONE;
                end else if (i_rx_valid && (i_rx_data == CMD_NEXT)) begin
                    w_pc_enable_nxt = 1'b1;
                end
            end
            ST_DONE: begin
                if (i_rx_valid && (i_rx_data == CMD_RESET)) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state        <= ST_IDLE;
            r_cnt_hi       <= '0;
            r_word_total   <= '0;
            r_word_idx     <= '0;
            r_byte_idx     <= '0;
            r_shift        <= '0;
            r_wr_en        <= 1'b0;
            r_wr_addr      <= '0;
            r_wr_data      <= '0;
            r_pc_clear     <= 1'b0;
            r_pc_enable    <= 1'b0;
            r_loaded_count <= '0;
            r_error        <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_cnt_hi       <= w_cnt_hi_nxt;
            r_word_total   <= w_word_total_nxt;
            r_word_idx     <= w_word_idx_nxt;
            r_byte_idx     <= w_byte_idx_nxt;
            r_shift        <= w_shift_nxt;
            r_wr_en        <= w_wr_en_nxt;
            r_wr_addr      <= w_wr_addr_nxt;
            r_wr_data      <= w_wr_data_nxt;
            r_pc_clear     <= w_pc_clear_nxt;
            r_pc_enable    <= w_pc_enable_nxt;
            r_loaded_count <= w_loaded_count_nxt;
            r_error        <= w_error_nxt;
        end
    end

    assign o_mem_wr_en    = r_wr_en;
    assign o_mem_wr_addr  = r_wr_addr;
    assign o_mem_wr_data  = r_wr_data;
    assign o_pc_clear     = r_pc_clear;
    assign o_pc_enable    = r_pc_enable;
    assign o_loaded_count = r_loaded_count;
    assign o_state        = r_state;
    assign o_done         = (r_state == ST_DONE);
    assign o_error        = r_error;

endmodule

// File: tb/tb_fetch_run_controller.sv
// tb/tb_fetch_run_controller.sv - directed self-checking bench for fetch_run_controller
module tb_fetch_run_controller;

    logic        clk;
    logic        rst_n;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        halt;
    logic        mem_wr_en;
    logic [10:0] mem_wr_addr;
    logic [31:0] mem_wr_data;
    logic        pc_clear;
    logic        pc_enable;
    logic [11:0] loaded_count;
    logic [2:0]  state;
    logic        done;
    logic        error;

    int n_assert = 0;
    int n_fail   = 0;

    fetch_run_controller #(
        .NB_INSTRUC(32), .NB_BYTE(8), .RAM_DEPTH_PROGRAM(2048), .NB_MEM_ADDR(11)
    ) dut (
        .i_clk(clk), .i_rst(rst_n), .i_rx_data(rx_data), .i_rx_valid(rx_valid), .i_halt(halt),
        .o_mem_wr_en(mem_wr_en), .o_mem_wr_addr(mem_wr_addr), .o_mem_wr_data(mem_wr_data),
        .o_pc_clear(pc_clear), .o_pc_enable(pc_enable), .o_loaded_count(loaded_count),
        .o_state(state), .o_done(done), .o_error(error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present one byte for one cycle; returns 1ns into the cycle after it was consumed
    task automatic send(input logic [7:0] b);
        @(posedge clk); #1;
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk); #1;
        rx_valid = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_wr_en"}, mem_wr_en, 0);
        chk({tag, "_pc_clear"}, pc_clear, 0);
        chk({tag, "_pc_enable"}, pc_enable, 0);
    endtask

    initial begin
        rst_n = 1'b0; rx_data = 8'h00; rx_valid = 1'b0; halt = 1'b0;
        repeat (3) tick();

        chk("rst_state", state, 0);
        chk("rst_loaded", loaded_count, 0);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        chk("rst_wr_addr", mem_wr_addr, 0);
        chk("rst_wr_data", mem_wr_data, 0);
        chk_quiet("rst");
        rst_n = 1'b1;
        tick();

        // Load two words
        send(8'h4C); chk("ld_cnt_hi", state, 1);
        send(8'h00); chk("ld_cnt_lo", state, 2);
        send(8'h02); chk("ld_load", state, 3);
        send(8'h20); send(8'h01); send(8'h00);
        chk("ld_partial_wr", mem_wr_en, 0);
        send(8'h05);
        chk("ld_w0_en", mem_wr_en, 1);
        chk("ld_w0_addr", mem_wr_addr, 0);
        chk("ld_w0_data", mem_wr_data, 64'h20010005);
        chk("ld_w0_state", state, 3);
        tick();
        chk("ld_w0_pulse", mem_wr_en, 0);
        send(8'h8C); send(8'h02); send(8'h00); send(8'h00);
        chk("ld_w1_en", mem_wr_en, 1);
        chk("ld_w1_addr", mem_wr_addr, 1);
        chk("ld_w1_data", mem_wr_data, 64'h8C020000);
        chk("ld_end_state", state, 0);
        chk("ld_count", loaded_count, 2);
        tick();
        chk("ld_end_pulse", mem_wr_en, 0);

        // Continuous run, stopped by pipeline HALT
        send(8'h43);
        chk("run_state", state, 4);
        chk("run_clear", pc_clear, 1);
        chk("run_en_first", pc_enable, 0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("run_en", pc_enable, 1);
            chk("run_clear_off", pc_clear, 0);
        end
        halt = 1'b1;
        tick();
        halt = 1'b0;
        chk("run_halt_state", state, 6);
        chk("run_halt_en", pc_enable, 0);
        chk("run_halt_done", done, 1);
        send(8'h41);
        chk("done_ignore", state, 6);
        send(8'h52);
        chk("done_r_state", state, 0);
        chk("done_r_done", done, 0);
        chk("done_r_count", loaded_count, 2);

        // Single step
        send(8'h53);
        chk("step_state", state, 5);
        chk("step_clear", pc_clear, 1);
        chk("step_en_first", pc_enable, 0);
        tick();
        chk("step_idle_en", pc_enable, 0);
        chk("step_clear_off", pc_clear, 0);
        for (int i = 0; i < 3; i++) begin
            send(8'h4E);
            chk("step_pulse", pc_enable, 1);
            tick();
            chk("step_pulse_end", pc_enable, 0);
        end
        @(posedge clk); #1;
        rx_data = 8'h4E; rx_valid = 1'b1; halt = 1'b1;
        @(posedge clk); #1;
        rx_valid = 1'b0; halt = 1'b0;
        chk("step_halt_wins_en", pc_enable, 0);
        chk("step_halt_state", state, 6);
        send(8'h52);
        chk("step_r_state", state, 0);

        // Run stopped by 'H' byte
        send(8'h43);
        tick();
        chk("runh_en", pc_enable, 1);
        send(8'h48);
        chk("runh_state", state, 6);
        tick();
        chk("runh_en_off", pc_enable, 0);
        send(8'h52);

        // Oversize count, then empty load
        send(8'h4C); send(8'h08); send(8'h01);
        chk("big_state", state, 0);
        chk("big_error", error, 1);
        chk("big_wr", mem_wr_en, 0);
        send(8'h4C);
        chk("clr_error", error, 0);
        chk("clr_state", state, 1);
        send(8'h00); send(8'h00);
        chk("zero_state", state, 0);
        chk("zero_count", loaded_count, 0);
        chk("zero_error", error, 0);
        send(8'h43);
        chk("zero_c_ignored", state, 0);
        chk_quiet("zero_c");

        // Maximum count is accepted
        send(8'h4C); send(8'h08); send(8'h00);
        chk("max_state", state, 3);
        chk("max_error", error, 0);
        #2 rst_n = 1'b0;
        #1 chk("max_rst_state", state, 0);
        tick(); rst_n = 1'b1;

        // Load one word, start run, reset while enabled
        send(8'h4C); send(8'h00); send(8'h01);
        send(8'h11); send(8'h22); send(8'h33); send(8'h44);
        chk("one_data", mem_wr_data, 64'h11223344);
        chk("one_count", loaded_count, 1);
        send(8'h43);
        tick();
        chk("rrun_en", pc_enable, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rrun_en_drop", pc_enable, 0);
        chk("rrun_state", state, 0);
        chk("rrun_count", loaded_count, 0);
        tick(); rst_n = 1'b1;

        // Reset in the middle of a word
        send(8'h4C); send(8'h00); send(8'h02);
        send(8'hAA); send(8'hBB);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_state", state, 0);
        chk("mid_wr_data", mem_wr_data, 0);
        chk_quiet("mid");
        tick(); rst_n = 1'b1;
        send(8'h43);
        chk("mid_c_ignored", state, 0);
        send(8'h4C); send(8'h00); send(8'h01);
        send(8'hCC); send(8'hDD); send(8'hEE); send(8'hFF);
        chk("mid_new_en", mem_wr_en, 1);
        chk("mid_new_addr", mem_wr_addr, 0);
        chk("mid_new_data", mem_wr_data, 64'hCCDDEEFF);

        // Unknown bytes in IDLE
        send(8'hFF);
        chk("ff_state", state, 0);
        chk_quiet("ff");
        send(8'h4E);
        chk("n_idle_state", state, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
